// File: rtl/order_tx.sv
`default_nettype none
// ============================================================================
// Module   : order_tx
// Brief    : FIFO-fed 32-bit MSB-first serial frame transmitter with a fixed
//            inter-frame gap and an optional 0xFFFFFFFF keepalive frame.
// Revision : 1.0
// ============================================================================
module order_tx #(
  parameter int DEPTH            = 4,
  parameter int GAP_CYCLES       = 2,
  parameter int KEEPALIVE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        CPU_RESETN,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        dataPingOut,
  output logic        comEnOut,
  output logic        busy,
  output logic [7:0]  frames_sent
);

  localparam int c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW   = c_AW + 1;
  localparam int c_KA_W = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam logic [31:0]       c_NULL_WORD = 32'hFFFF_FFFF;
  localparam logic [c_CW-1:0]   c_DEPTH     = c_CW'(DEPTH);
  localparam logic [c_KA_W-1:0] c_KA_LAST   = c_KA_W'(KEEPALIVE_CYCLES - 1);
  localparam logic [3:0]        c_GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam bit                c_KA_EN     = (KEEPALIVE_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [31:0]       r_shreg;
  logic              r_en;
  logic              r_null;
  logic [4:0]        r_bit_cnt;
  logic [3:0]        r_gap_cnt;
  logic [c_KA_W-1:0] r_ka_cnt;
  logic [7:0]        r_frames;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_start_null;
  logic w_start;
  logic w_end_frame;
  logic w_ka_due;

  assign w_full   = (r_count == c_DEPTH);
  assign w_empty  = (r_count == '0);
  assign in_ready = CPU_RESETN & ~w_full;
  // The reserved null word is consumed at the port but never queued.
  assign w_push   = in_valid & in_ready & (in_data != c_NULL_WORD);
  assign w_ka_due = c_KA_EN && (r_ka_cnt == c_KA_LAST);
  assign w_start  = w_pop | w_start_null;

  assign dataPingOut = r_shreg[31];
  assign comEnOut    = r_en;
  assign frames_sent = r_frames;
  assign busy        = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (!CPU_RESETN) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // The last gap edge doubles as a frame-start edge so exactly GAP_CYCLES
  // low cycles separate back-to-back frames.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_start_null = 1'b0;
    w_end_frame  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
        end else if (w_ka_due) begin
          w_start_null = 1'b1;
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == 5'd31) begin
          w_end_frame = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!CPU_RESETN) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_shreg   <= '0;
      r_en      <= 1'b0;
      r_null    <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ka_cnt  <= '0;
      r_frames  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase

      // Shift register zero-fills, and is cleared at frame end, so the
      // serial line sits at 0 whenever the enable is low.
      if (w_start) begin
        r_shreg   <= w_pop ? r_mem[r_rd_ptr] : c_NULL_WORD;
        r_en      <= 1'b1;
        r_null    <= w_start_null;
        r_bit_cnt <= '0;
      end else if (w_end_frame) begin
        r_shreg <= '0;
        r_en    <= 1'b0;
        if (!r_null) r_frames <= r_frames + 8'd1;
      end else if (r_state == S_SHIFT) begin
        r_shreg   <= {r_shreg[30:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end

      if (w_end_frame)            r_gap_cnt <= '0;
      else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt + 4'd1;

      if (w_start)
        r_ka_cnt <= '0;
      else if (c_KA_EN && (r_state == S_IDLE) && w_empty)
        r_ka_cnt <= r_ka_cnt + c_KA_W'(1);
    end
  end

endmodule
`default_nettype wire
